fc_mac_accumulator: RTL
=======================

FC_MAC_ACCUMULATOR -- requirements
Module: fc_mac_accumulator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 10, giving the width of the term counter (max 2^CNT_W-1 terms per dot product).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle pulse that begins a dot product.
REQ-005 The block SHALL have port num_terms, input, CNT_W, the number of input/weight pairs, sampled on start.
REQ-006 The block SHALL have port bias, input, 16, signed Q5.11 bias, sampled on start.
REQ-007 The block SHALL have port in_valid, input, 1, marking the in_data/in_weight beat as valid.
REQ-008 The block SHALL have port in_ready, output, 1, high when a beat can be accepted.
REQ-009 The block SHALL have ports in_data and in_weight, input, 16 each, signed Q5.11 operands.
REQ-010 The block SHALL have port result, output, 32, signed Q10.22 sum for the downstream 32-to-16 fixed-point saturation stage.
REQ-011 The block SHALL have port out_valid, output, 1, marking result as valid.
REQ-012 The block SHALL have port out_ready, input, 1, consumer acceptance.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port ovf, output, 1, sticky accumulator-overflow flag for the current dot product.

Function
REQ-015 The block SHALL implement states IDLE, ACCUM and DONE.
REQ-016 IDLE: start=1 with num_terms>0 SHALL load acc = sign-extended bias<<11, load the counter with num_terms, clear ovf, and go to ACCUM.
REQ-017 IDLE: start=1 with num_terms=0 SHALL load acc = bias<<11 and go directly to DONE.
REQ-018 ACCUM: in_ready SHALL be 1; in IDLE and DONE in_ready SHALL be 0.
REQ-019 A beat SHALL be accepted when in_valid and in_ready are both 1; acc += in_data*in_weight (full 32-bit signed product, Q10.22), and the counter decrements.
REQ-020 Acceptance of the beat with counter=1 SHALL move the state to DONE on the same edge, so out_valid rises the cycle after the last beat.
REQ-021 DONE: out_valid SHALL be 1 and result SHALL equal acc, held stable until out_ready=1; out_valid&out_ready SHALL return the state to IDLE.
REQ-022 ACCUM cycles with in_valid=0 SHALL leave acc and the counter unchanged.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 ovf SHALL remain valid with result in DONE and SHALL clear only on the next accepted start or on reset.

Reset
REQ-025 rst=1 SHALL force state IDLE, acc=0, counter=0, result=0, out_valid=0, in_ready=0, busy=0, ovf=0 on the next edge.
REQ-026 rst asserted mid-ACCUM or mid-DONE SHALL abort the operation, discard the partial sum, and take priority over all other inputs.

Configuration
REQ-027 With macro FC_MAC_ACC_SAT_EN defined, an addition whose true sum exceeds the 32-bit signed range SHALL clamp acc to 32'h7FFFFFFF (positive) or 32'h80000000 (negative) and set ovf.
REQ-028 Without FC_MAC_ACC_SAT_EN, acc SHALL wrap modulo 2^32, and ovf SHALL still set on signed overflow, as a diagnostic only.

Verification
REQ-029 Single term: start, num_terms=1, bias=0, beat 0x0800*0x0800 (1.0*1.0) -> out_valid one cycle after the beat, result=32'h00400000.
REQ-030 Bias only: num_terms=0, bias=0x1000 (2.0) -> DONE the cycle after start, result=32'h00800000, no in_ready.
REQ-031 Four terms 0x0800*0xF800 (1.0*-1.0), with in_valid gaps and bias=0 -> result=32'hFF000000 (-4.0), ovf=0.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable; a start pulse during this time is ignored; out_ready=1 -> IDLE.
REQ-033 Overflow: 600 beats of 0x7FFF*0x7FFF -> with FC_MAC_ACC_SAT_EN, result=32'h7FFFFFFF and ovf=1; without the macro, wrapped value and ovf=1.
REQ-034 rst pulse after 2 of 4 beats -> IDLE with all outputs 0; a following 1-term run gives the correct result, with no residue from the aborted run.

Source files
------------

// File: rtl/fc_mac_accumulator.sv
// Fixed-point dot-product accumulator for a fully-connected layer.
// Q5.11 input/weight beats accumulate into a Q10.22 sum seeded with the bias.
//
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   start, num_terms, bias   - begin a dot product; count and bias sampled on start
//   in_valid/in_ready        - operand beat handshake (in_data, in_weight)
//   result/out_valid/out_ready - finished sum handshake
//   busy                     - high whenever not IDLE
//   ovf                      - sticky signed-overflow flag for the current dot product
//
// Optional feature: define FC_MAC_ACC_SAT_EN to clamp the accumulator on
// overflow instead of wrapping modulo 2^32.
module fc_mac_accumulator #(
    parameter int CNT_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_terms,
    input  logic [15:0]             bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             in_data,
    input  logic [15:0]             in_weight,
    output logic [31:0]             result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       acc;
    logic [31:0]       acc_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;

    logic signed [31:0] prod;
    logic [32:0]        sum;
    logic               sum_ovf;
    logic [31:0]        sum_fixed;
    logic [31:0]        bias_ext;

    // Q5.11 x Q5.11 gives a full-width Q10.22 product.
    assign prod = $signed(in_data) * $signed(in_weight);

    // One guard bit: a signed overflow shows up as the top two bits differing.
    assign sum     = {acc[31], acc} + {prod[31], prod};
    assign sum_ovf = sum[32] ^ sum[31];

`ifdef FC_MAC_ACC_SAT_EN
    // The guard bit carries the true sign of the sum, which picks the rail.
    assign sum_fixed = sum_ovf ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                               : sum[31:0];
`else
    assign sum_fixed = sum[31:0];
`endif

    // Align the Q5.11 bias to the Q10.22 accumulator.
    assign bias_ext = {{5{bias[15]}}, bias, 11'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        result     = '0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    acc_next = bias_ext;
                    cnt_next = num_terms;
                    ovf_next = 1'b0;
                    if (num_terms != '0) begin
                        state_next = ACCUM;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_next = sum_fixed;
                    cnt_next = cnt - CNT_W'(1);
                    if (sum_ovf) begin
                        ovf_next = 1'b1;
                    end
                    if (cnt == CNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                result    = acc;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
